vdg_timing_gen: RTL and testbench
=================================

VDG_TIMING_GEN -- requirements
Module: vdg_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 256: visible dots per line.
REQ-002 Parameter H_FP, default 48; H_SYNC, default 32; H_BP, default 120: front porch, sync and back porch in dots. H_TOTAL = 456.
REQ-003 Parameter V_ACTIVE, default 192; V_FP, default 26; V_SYNC, default 3; V_BP, default 41: in lines. V_TOTAL = 262.
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 pix_en  input  1  dot-advance strobe from the upstream double-rate dot counter, one per dot.
REQ-007 hcount  output  9  current dot in line, 0..H_TOTAL-1.
REQ-008 vcount  output  9  current line in field, 0..V_TOTAL-1.
REQ-009 hs_n  output  1  horizontal sync, active-low.
REQ-010 fs_n  output  1  field sync, active-low.
REQ-011 de  output  1  display enable, high in the active window.
REQ-012 row  output  4  character scan row, 0..11.
REQ-013 vaddr  output  9  text cell address, 32 columns x 16 rows.
REQ-014 line_start  output  1  one-clk pulse.
REQ-015 frame_start  output  1  one-clk pulse.

Function
REQ-016 Counters advance only on a clk edge with pix_en=1; with pix_en=0 every output holds, and pulses read 0.
REQ-017 hcount increments per dot; at H_TOTAL-1 it wraps to 0 and vcount increments.
REQ-018 vcount wraps from V_TOTAL-1 to 0 on the same edge that hcount wraps.
REQ-019 Every output is registered and consistent with the hcount/vcount it accompanies: zero added latency.
REQ-020 de=1 iff hcount<H_ACTIVE and vcount<V_ACTIVE.
REQ-021 hs_n=0 iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, i.e. dots 304..335.
REQ-022 fs_n=0 iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, i.e. lines 218..220.
REQ-023 line_start=1 for one clk on the advancing edge where hcount becomes 0.
REQ-024 frame_start=1 for one clk on the advancing edge where hcount and vcount both become 0.
REQ-025 row increments at each line wrap while vcount<V_ACTIVE; 11 wraps to 0; forced to 0 when vcount becomes 0.
REQ-026 vaddr is cell base plus column: column increments every 8 active dots; base advances 32 cells when row wraps 11->0.
REQ-027 vaddr = (vcount/12)*32 + hcount/8 during de, computed with counters only, no divider.
REQ-028 Outside de, vaddr holds its last active value; it returns to 0 at frame_start.
REQ-029 Width rule: all counters are 9-bit unsigned; no comparison may overflow at H_TOTAL-1 or V_TOTAL-1.

Reset
REQ-030 Reset (any time, including mid-line) forces hcount=0, vcount=0, row=0, vaddr=0, hs_n=1, fs_n=1, de=1, line_start=0, frame_start=0.
REQ-031 On the first pix_en after reset release, hcount becomes 1 and no start pulse is issued.
REQ-032 reset takes priority over pix_en.

Structure
REQ-033 Package vdg_timing_pkg holds the default timing constants, H_TOTAL/V_TOTAL derivations, and the 32x12 text geometry constants.
REQ-034 One sub-module, vdg_axis_counter, holds wrap count plus sync/active decode; it is instantiated once horizontal and once vertical, with carry-in chaining.

Verification
REQ-035 Reset, then 456 pix_en -> hcount back to 0, vcount=1, line_start=1 on that edge only.
REQ-036 Run 119472 pix_en (456x262) -> frame_start=1 exactly once, at return to 0,0; fs_n low for exactly 3 lines (218..220).
REQ-037 Line 0, dots 304..335 -> hs_n=0 for exactly 32 dots; de=0 from dot 256.
REQ-038 At vcount=12, hcount=16 -> row=0, vaddr=34; at vcount=191, hcount=255 -> row=11, vaddr=511.
REQ-039 pix_en toggled 1-0-1 with random gaps -> counters identical to a gapless run at equal pix_en count.
REQ-040 reset asserted at vcount=100, hcount=200 -> all outputs reach reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/vdg_timing_pkg.sv
// Video display generator timing constants shared by the timing generator
// and its axis counters.
//   Default horizontal timing: 256 active, 48 front porch, 32 sync, 120 back porch (456 dots).
//   Default vertical timing:   192 active, 26 front porch, 3 sync, 41 back porch (262 lines).
//   Text geometry: 32 columns x 16 rows of 8-dot x 12-line character cells.
package vdg_timing_pkg;

  localparam int CNT_W = 9;
  localparam int ROW_W = 4;

  localparam int H_ACTIVE_DEF = 256;
  localparam int H_FP_DEF     = 48;
  localparam int H_SYNC_DEF   = 32;
  localparam int H_BP_DEF     = 120;

  localparam int V_ACTIVE_DEF = 192;
  localparam int V_FP_DEF     = 26;
  localparam int V_SYNC_DEF   = 3;
  localparam int V_BP_DEF     = 41;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int H_TOTAL_DEF = axis_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOTAL_DEF = axis_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

  localparam int CHAR_W    = 8;   // dots per character cell
  localparam int CHAR_H    = 12;  // scan lines per character cell
  localparam int TEXT_COLS = 32;
  localparam int TEXT_ROWS = 16;

endpackage

// File: rtl/vdg_axis_counter.sv
// One timing axis: a wrapping position counter with registered sync and
// look-ahead active decode.
//   clk, reset    : clock, asynchronous active-high reset
//   inc_i         : advance by one position (carry-in)
//   count_o       : registered position 0..TOTAL-1
//   count_d_o     : position after this edge (next-state)
//   wrap_o        : carry-out, high when this edge wraps TOTAL-1 -> 0
//   active_d_o    : next position lies in the active window
//   sync_n_o      : registered active-low sync for the current position
module vdg_axis_counter
  import vdg_timing_pkg::*;
#(
  parameter int TOTAL      = H_TOTAL_DEF,
  parameter int ACTIVE     = H_ACTIVE_DEF,
  parameter int SYNC_START = H_ACTIVE_DEF + H_FP_DEF,
  parameter int SYNC_END   = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] count_d_o,
  output logic             wrap_o,
  output logic             active_d_o,
  output logic             sync_n_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             sync_n_q, sync_n_d;
  logic             wrap;

  // Sync and active decode from the next count so they line up with the
  // count they accompany once registered.
  always_comb begin
    wrap     = inc_i && (count_q == CNT_W'(TOTAL - 1));
    count_d  = count_q;
    if (wrap)
      count_d = '0;
    else if (inc_i)
      count_d = count_q + 1'b1;
    sync_n_d = !((count_d >= CNT_W'(SYNC_START)) && (count_d < CNT_W'(SYNC_END)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      sync_n_q <= 1'b1;
    end else begin
      count_q  <= count_d;
      sync_n_q <= sync_n_d;
    end
  end

  assign count_o    = count_q;
  assign count_d_o  = count_d;
  assign wrap_o     = wrap;
  assign active_d_o = (count_d < CNT_W'(ACTIVE));
  assign sync_n_o   = sync_n_q;

endmodule

// File: rtl/vdg_timing_gen.sv
// Video display generator raster timing: dot/line counters, syncs, display
// enable, character scan row and text cell address, all registered and
// aligned with hcount/vcount.
//   clk, reset              : clock, asynchronous active-high reset
//   pix_en                  : one strobe per dot; nothing advances without it
//   hcount, vcount          : current dot and line
//   hs_n, fs_n              : active-low horizontal and field sync
//   de                      : display enable (active window)
//   row                     : character scan row 0..11
//   vaddr                   : text cell address, row base + column
//   line_start, frame_start : one-clk pulses when a line / field begins
module vdg_timing_gen
  import vdg_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hs_n,
  output logic             fs_n,
  output logic             de,
  output logic [ROW_W-1:0] row,
  output logic [CNT_W-1:0] vaddr,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int COL_LSB = $clog2(CHAR_W);

  logic [CNT_W-1:0] h_d, v_d;
  logic             h_wrap, v_wrap, h_act_d, v_act_d;

  logic             de_q, de_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] base_q, base_d;
  logic [CNT_W-1:0] vaddr_q, vaddr_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;

  vdg_axis_counter #(
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_END   (H_ACTIVE + H_FP + H_SYNC)
  ) u_h_axis (
    .clk        (clk),
    .reset      (reset),
    .inc_i      (pix_en),
    .count_o    (hcount),
    .count_d_o  (h_d),
    .wrap_o     (h_wrap),
    .active_d_o (h_act_d),
    .sync_n_o   (hs_n)
  );

  vdg_axis_counter #(
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_END   (V_ACTIVE + V_FP + V_SYNC)
  ) u_v_axis (
    .clk        (clk),
    .reset      (reset),
    .inc_i      (h_wrap),
    .count_o    (vcount),
    .count_d_o  (v_d),
    .wrap_o     (v_wrap),
    .active_d_o (v_act_d),
    .sync_n_o   (fs_n)
  );

  always_comb begin
    de_d          = h_act_d && v_act_d;
    line_start_d  = h_wrap;
    frame_start_d = h_wrap && v_wrap;
    row_d         = row_q;
    base_d        = base_q;
    vaddr_d       = vaddr_q;

    // Row and text-row base step at line wraps leaving an active line.
    if (h_wrap) begin
      if (v_wrap) begin
        row_d  = '0;
        base_d = '0;
      end else if (vcount < CNT_W'(V_ACTIVE)) begin
        if (row_q == ROW_W'(CHAR_H - 1)) begin
          row_d  = '0;
          base_d = base_q + CNT_W'(TEXT_COLS);
        end else begin
          row_d = row_q + 1'b1;
        end
      end
    end

    // Column counted incrementally: reload the base at the first active
    // dot, then bump once per character cell. Holds outside the window.
    if (pix_en && de_d) begin
      if (h_d == '0)
        vaddr_d = base_d;
      else if (h_d[COL_LSB-1:0] == '0)
        vaddr_d = vaddr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de_q          <= 1'b1;
      row_q         <= '0;
      base_q        <= '0;
      vaddr_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      de_q          <= de_d;
      row_q         <= row_d;
      base_q        <= base_d;
      vaddr_q       <= vaddr_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign de          = de_q;
  assign row         = row_q;
  assign vaddr       = vaddr_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vdg_timing_gen.sv
// Scoreboard bench for vdg_timing_gen. Horizontal timing is the default;
// the vertical axis is shortened (36 active lines = 3 text rows) so that
// several full fields fit in a short run.
module tb_vdg_timing_gen;

  localparam int HA = 256, HFP = 48, HS = 32, HBP = 120;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VA = 36, VFP = 4, VS = 3, VBP = 5;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_en;
  logic [8:0] hcount, vcount, vaddr;
  logic       hs_n, fs_n, de, line_start, frame_start;
  logic [3:0] row;

  vdg_timing_gen #(
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pix_en      (pix_en),
    .hcount      (hcount),
    .vcount      (vcount),
    .hs_n        (hs_n),
    .fs_n        (fs_n),
    .de          (de),
    .row         (row),
    .vaddr       (vaddr),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h, v, hs_n, fs_n, de, row, vaddr, ls, fst;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   ls_seen = 0;
  int   fs_seen = 0;
  int   n = 0;

  // Reference: everything follows from n, the number of dots advanced since
  // reset, and whether this clk advanced.
  function automatic exp_t model(input int dots, input bit adv);
    exp_t e;
    int   line;
    line    = dots / HT;
    e.h     = dots % HT;
    e.v     = line % VT;
    e.de    = (e.h < HA && e.v < VA) ? 1 : 0;
    e.hs_n  = (e.h >= HA + HFP && e.h < HA + HFP + HS) ? 0 : 1;
    e.fs_n  = (e.v >= VA + VFP && e.v < VA + VFP + VS) ? 0 : 1;
    e.row   = (e.v < VA) ? e.v % 12 : VA % 12;
    if (e.v < VA)
      e.vaddr = (e.v / 12) * 32 + ((e.h < HA) ? e.h / 8 : HA / 8 - 1);
    else
      e.vaddr = ((VA - 1) / 12) * 32 + HA / 8 - 1;
    e.vaddr = e.vaddr % 512;
    e.ls    = (adv && e.h == 0) ? 1 : 0;
    e.fst   = (e.ls == 1 && e.v == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic check(input exp_t e, input string tag);
    bit bad;
    bad = 0;
    vectors++;
    if (hcount !== 9'(e.h)) begin bad = 1; $display("FAIL %s hcount got %0d want %0d", tag, hcount, e.h); end
    if (vcount !== 9'(e.v)) begin bad = 1; $display("FAIL %s vcount got %0d want %0d", tag, vcount, e.v); end
    if (hs_n !== 1'(e.hs_n)) begin bad = 1; $display("FAIL %s hs_n got %b want %0d (h=%0d)", tag, hs_n, e.hs_n, e.h); end
    if (fs_n !== 1'(e.fs_n)) begin bad = 1; $display("FAIL %s fs_n got %b want %0d (v=%0d)", tag, fs_n, e.fs_n, e.v); end
    if (de !== 1'(e.de)) begin bad = 1; $display("FAIL %s de got %b want %0d (h=%0d v=%0d)", tag, de, e.de, e.h, e.v); end
    if (row !== 4'(e.row)) begin bad = 1; $display("FAIL %s row got %0d want %0d (v=%0d)", tag, row, e.row, e.v); end
    if (vaddr !== 9'(e.vaddr)) begin bad = 1; $display("FAIL %s vaddr got %0d want %0d (h=%0d v=%0d)", tag, vaddr, e.vaddr, e.h, e.v); end
    if (line_start !== 1'(e.ls)) begin bad = 1; $display("FAIL %s line_start got %b want %0d (h=%0d v=%0d)", tag, line_start, e.ls, e.h, e.v); end
    if (frame_start !== 1'(e.fst)) begin bad = 1; $display("FAIL %s frame_start got %b want %0d (h=%0d v=%0d)", tag, frame_start, e.fst, e.h, e.v); end
    if (bad) miscompares++;
  endtask

  // Monitor: one expected entry per clk edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e, "sb");
        if (line_start === 1'b1) ls_seen++;
        if (frame_start === 1'b1) fs_seen++;
      end
    end
  end

  task automatic step(input bit gapless);
    @(negedge clk);
    pix_en = gapless ? 1'b1 : ($urandom_range(0, 9) != 0);
    if (pix_en) n++;
    sb.push_back(model(n, pix_en));
  endtask

  task automatic hold_reset(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      pix_en = 1'($urandom_range(0, 1));
      sb.push_back(model(0, 0));
    end
  endtask

  int cyc;
  int seg1_lines;

  initial begin
    reset  = 1'b1;
    pix_en = 1'b0;
    @(posedge clk);
    #1 check(model(0, 0), "reset_state");
    hold_reset(3);

    // Release; first advance gives hcount=1 with no pulse, first line gapless.
    @(negedge clk);
    reset  = 1'b0;
    pix_en = 1'b1;
    n      = 1;
    sb.push_back(model(n, 1));
    while (n < HT + 4) step(1'b1);

    // Random gaps up to line 10, dot 200, then asynchronous reset mid-line.
    cyc = 0;
    while (n < 10 * HT + 200 && cyc < 20000) begin step(1'b0); cyc++; end
    seg1_lines = n / HT;
    if (n != 10 * HT + 200)
      $display("FAIL seg1_budget dots got %0d want %0d", n, 10 * HT + 200);
    @(negedge clk);
    pix_en = 1'b1;
    reset  = 1'b1;
    #1 check(model(0, 0), "async_reset");
    sb.push_back(model(0, 0));
    hold_reset(2);
    @(negedge clk);
    reset = 1'b0;
    pix_en = 1'b1;
    n = 1;
    sb.push_back(model(n, 1));

    // Two full fields plus a little, random gaps.
    cyc = 0;
    while (n < 2 * FRAME + 700 && cyc < 70000) begin step(1'b0); cyc++; end
    if (n != 2 * FRAME + 700) begin
      vectors++; miscompares++;
      $display("FAIL run_budget dots got %0d want %0d", n, 2 * FRAME + 700);
    end

    @(negedge clk);
    pix_en = 1'b0;
    sb.push_back(model(n, 0));
    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain queue_left got %0d want 0", sb.size());
    end
    vectors++;
    if (fs_seen != n / FRAME) begin
      miscompares++;
      $display("FAIL frame_start_count got %0d want %0d", fs_seen, n / FRAME);
    end
    vectors++;
    if (ls_seen != seg1_lines + n / HT) begin
      miscompares++;
      $display("FAIL line_start_count got %0d want %0d", ls_seen, seg1_lines + n / HT);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
